// File: rtl/altitude_integrator.sv
// altitude_integrator
//   Integrates burn-phase velocity samples into altitude, then runs a
//   ballistic coast with a fixed per-tick gravity decrement until the
//   velocity reaches zero (apogee), after which everything freezes.
//   Units: velocity in nm/s, accumulator in fm, altitude in mm.
//
// Ports
//   clk           in   rising-edge clock (1 us period)
//   resetb        in   synchronous active-high reset
//   launch        in   one-cycle start pulse (IDLE -> BURN)
//   burnout       in   one-cycle end-of-burn pulse (BURN -> COAST)
//   v_valid       in   velocity sample strobe (BURN only)
//   velocity      in   [63:0] sample, nm/s
//   altitude_mm   out  [63:0] acc / 1e12, truncated, saturating
//   cur_velocity  out  [63:0] velocity last integrated, nm/s
//   state         out  [1:0]  0=IDLE 1=BURN 2=COAST 3=DONE
//   apogee        out  one-cycle pulse coincident with first DONE cycle
//   sample_count  out  [31:0] samples integrated since launch
module altitude_integrator #(
  parameter int DT_US   = 20,
  parameter int GRAVITY = 9_799,
  parameter int ACC_W   = 128
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        launch,
  input  logic        burnout,
  input  logic        v_valid,
  input  logic [63:0] velocity,
  output logic [63:0] altitude_mm,
  output logic [63:0] cur_velocity,
  output logic [1:0]  state,
  output logic        apogee,
  output logic [31:0] sample_count
);

  localparam logic [63:0]      G_STEP = 64'(GRAVITY * DT_US);
  localparam logic [31:0]      DT_W   = 32'(DT_US);
  localparam int               TW     = (DT_US > 1) ? $clog2(DT_US) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(DT_US - 1);
  localparam logic [ACC_W-1:0] SCALE  = ACC_W'(64'd1_000_000_000_000);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURN  = 2'd1,
    S_COAST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            st, st_nxt;
  logic [ACC_W-1:0]  acc;
  logic              sat;
  logic [TW-1:0]     tick;

  // next-state / datapath controls
  logic              do_int;     // integrate int_vel this edge
  logic              coast_step; // coast tick boundary
  logic              stop;       // coast step reaching zero velocity
  logic [63:0]       int_vel;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_nxt;
  logic [ACC_W-1:0]  quot;
  logic [63:0]       alt_nxt;

  always_comb begin
    st_nxt     = st;
    do_int     = 1'b0;
    coast_step = 1'b0;
    stop       = 1'b0;
    int_vel    = velocity;
    case (st)
      S_IDLE:  if (launch) st_nxt = S_BURN;
      S_BURN: begin
        // a sample coincident with burnout is integrated before coasting
        if (v_valid) do_int = 1'b1;
        if (burnout) st_nxt = S_COAST;
      end
      S_COAST: begin
        if (tick == TICK_LAST) begin
          coast_step = 1'b1;
          do_int     = 1'b1;
          int_vel    = cur_velocity;
          if (cur_velocity <= G_STEP) begin
            stop   = 1'b1;
            st_nxt = S_DONE;
          end
        end
      end
      default: ;
    endcase
  end

  // 64x32 product zero-extended; carry out of the add means saturation
  always_comb begin
    prod    = ACC_W'(int_vel) * ACC_W'(DT_W);
    sum     = {1'b0, acc} + {1'b0, prod};
    acc_nxt = (sat || sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
    quot    = acc / SCALE;
    alt_nxt = (|quot[ACC_W-1:64]) ? '1 : quot[63:0];
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      st           <= S_IDLE;
      acc          <= '0;
      sat          <= 1'b0;
      tick         <= '0;
      cur_velocity <= '0;
      sample_count <= '0;
      altitude_mm  <= '0;
      apogee       <= 1'b0;
    end else begin
      st          <= st_nxt;
      apogee      <= stop;
      altitude_mm <= alt_nxt;  // one cycle behind acc
      if (do_int) begin
        acc          <= acc_nxt;
        sat          <= sat | sum[ACC_W];
        sample_count <= sample_count + 32'd1;
      end
      if (st == S_BURN && v_valid)
        cur_velocity <= velocity;
      if (coast_step)
        cur_velocity <= stop ? 64'd0 : cur_velocity - G_STEP;
      if (st == S_BURN && burnout)
        tick <= '0;
      else if (st == S_COAST)
        tick <= coast_step ? '0 : tick + TW'(1);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_altitude_integrator.sv
module tb_altitude_integrator;
  localparam int DT = 20;
  localparam logic [63:0] GSTEP = 64'd195_980;

  logic        clk = 0;
  logic        resetb, launch, burnout, v_valid;
  logic [63:0] velocity;
  logic [63:0] altitude_mm, cur_velocity;
  logic [1:0]  state;
  logic        apogee;
  logic [31:0] sample_count;

  altitude_integrator dut (
    .clk(clk), .resetb(resetb), .launch(launch), .burnout(burnout),
    .v_valid(v_valid), .velocity(velocity), .altitude_mm(altitude_mm),
    .cur_velocity(cur_velocity), .state(state), .apogee(apogee),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase number, accumulator in fm, countdown to next coast step.
  int           m_phase;
  logic [127:0] m_acc;
  logic [63:0]  m_alt, m_vel;
  logic [31:0]  m_cnt;
  logic         m_apo;
  int           m_cd;

  function automatic logic [127:0] sat_add(input logic [127:0] a, input logic [63:0] v);
    logic [128:0] s;
    s = {1'b0, a} + 129'(v) * 129'(DT);
    return s[128] ? {128{1'b1}} : s[127:0];
  endfunction

  function automatic logic [63:0] mm_of(input logic [127:0] a);
    logic [127:0] q;
    q = a / 128'd1_000_000_000_000;
    return (q > 128'(64'hFFFF_FFFF_FFFF_FFFF)) ? 64'hFFFF_FFFF_FFFF_FFFF : q[63:0];
  endfunction

  always @(posedge clk) begin
    if (resetb) begin
      m_phase <= 0; m_acc <= '0; m_alt <= '0; m_vel <= '0;
      m_cnt <= '0; m_apo <= 0; m_cd <= 0;
    end else begin
      m_apo <= 0;
      m_alt <= mm_of(m_acc);
      if (m_phase == 0) begin
        if (launch) m_phase <= 1;
      end else if (m_phase == 1) begin
        if (v_valid) begin
          m_acc <= sat_add(m_acc, velocity);
          m_vel <= velocity;
          m_cnt <= m_cnt + 1;
        end
        if (burnout) begin
          m_phase <= 2;
          m_cd <= DT;
        end
      end else if (m_phase == 2) begin
        if (m_cd == 1) begin
          m_cd  <= DT;
          m_acc <= sat_add(m_acc, m_vel);
          m_cnt <= m_cnt + 1;
          if (m_vel > GSTEP) m_vel <= m_vel - GSTEP;
          else begin
            m_vel <= 0; m_apo <= 1; m_phase <= 3;
          end
        end else m_cd <= m_cd - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("altitude_mm", altitude_mm, m_alt);
      chk("cur_velocity", cur_velocity, m_vel);
      chk("state", state, 128'(m_phase));
      chk("apogee", apogee, m_apo);
      chk("sample_count", sample_count, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    resetb = 1; cyc(); resetb = 0;
  endtask

  task automatic pulse_launch();
    launch = 1; cyc(); launch = 0;
  endtask

  task automatic run_burn();
    pulse_launch();
    chk("burn_state_entry", state, 1);
    launch = 1; cyc(); launch = 0;  // launch during BURN does nothing
    chk("launch_in_burn_state", state, 1);
    chk("launch_in_burn_cnt", sample_count, 0);
    for (int i = 0; i < 5; i++) begin
      v_valid = 1; velocity = 64'd100_000_000_000; cyc();
      v_valid = 0; cyc();
    end
    chk("burn_cnt", sample_count, 5);
    chk("burn_alt", altitude_mm, 10);
    chk("burn_state", state, 1);
    chk("burn_vel", cur_velocity, 64'd100_000_000_000);
  endtask

  initial begin
    int n;
    resetb = 1; launch = 0; burnout = 0; v_valid = 0; velocity = 0;

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      launch = 1'($urandom); burnout = 1'($urandom); v_valid = 1'($urandom);
      velocity = {$urandom, $urandom};
      cyc();
      chk_en = 1;
      chk("rst_alt", altitude_mm, 0);
      chk("rst_state", state, 0);
      chk("rst_apogee", apogee, 0);
      chk("rst_cnt", sample_count, 0);
      chk("rst_vel", cur_velocity, 0);
    end
    resetb = 0; launch = 0; burnout = 0; v_valid = 0; velocity = 0;

    // v_valid in IDLE ignored
    v_valid = 1; velocity = 64'd123_456; cyc(); v_valid = 0; cyc();
    chk("idle_vvalid_cnt", sample_count, 0);
    chk("idle_vvalid_vel", cur_velocity, 0);
    chk("idle_vvalid_state", state, 0);

    // burn integration
    run_burn();

    // coast to apogee
    do_reset();
    pulse_launch();
    v_valid = 1; velocity = 64'd1_000_000; cyc(); v_valid = 0;
    burnout = 1; cyc(); burnout = 0;
    chk("coast_entry_state", state, 2);
    n = 0;
    while (apogee !== 1'b1 && n < 200) begin cyc(); n++; end
    chk("apogee_latency", n, 120);
    chk("apogee_state", state, 3);
    chk("apogee_vel", cur_velocity, 0);
    chk("apogee_cnt", sample_count, 7);
    cyc();
    chk("apogee_one_cycle", apogee, 0);
    chk("apogee_alt", altitude_mm, 0);
    launch = 1; cyc(); launch = 0;
    chk("done_launch_state", state, 3);
    chk("done_launch_cnt", sample_count, 7);

    // simultaneous v_valid and burnout
    do_reset();
    pulse_launch();
    v_valid = 1; burnout = 1; velocity = 64'd50_000_000_000; cyc();
    v_valid = 0; burnout = 0;
    chk("simul_vel", cur_velocity, 64'd50_000_000_000);
    chk("simul_state", state, 2);
    chk("simul_cnt", sample_count, 1);
    n = 0;
    while (sample_count == 32'd1 && n < 100) begin
      cyc(); n++;
      if (n == 1) chk("simul_alt", altitude_mm, 1);
    end
    chk("simul_first_step", n, 20);
    chk("simul_step_vel", cur_velocity, 64'd50_000_000_000 - GSTEP);

    // reset mid-coast, 50 cycles after burnout
    repeat (30) cyc();
    chk("midcoast_state", state, 2);
    do_reset();
    chk("midrst_state", state, 0);
    chk("midrst_alt", altitude_mm, 0);
    chk("midrst_vel", cur_velocity, 0);
    chk("midrst_cnt", sample_count, 0);
    chk("midrst_apogee", apogee, 0);
    run_burn();

    cyc();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/altitude_integrator.md
# altitude_integrator

Downstream of the velocity stage. Consumes the burn-phase velocity samples and integrates them into altitude. After burnout it propagates a ballistic coast using a fixed gravity decrement, detects apogee and freezes the result. All arithmetic is integer fixed-point; the clock period is 1 µs.

## Interface
- DT_US, 20: µs represented by one sample; also the coast tick period in clocks.
- GRAVITY, 9_799: g in mm/s²; the per-sample coast decrement is G_STEP = GRAVITY*DT_US in nm/s.
- ACC_W, 128: accumulator width, in fm (1e-15 m).

- clk  in  1  clock, rising edge.
- resetb  in  1  synchronous, active-high reset; clears all state when sampled 1.
- launch  in  1  one-cycle start pulse.
- burnout  in  1  one-cycle end-of-burn pulse.
- v_valid  in  1  velocity sample strobe.
- velocity  in  64  unsigned, nm/s (9 decimals of m/s).
- altitude_mm  out  64  integrated altitude, mm, truncated.
- cur_velocity  out  64  velocity last integrated, nm/s.
- state  out  2  0=IDLE 1=BURN 2=COAST 3=DONE.
- apogee  out  1  one-cycle pulse on entry to DONE.
- sample_count  out  32  samples integrated since launch.

## Operation
- **Reset values:** every output is 0. The accumulator, the tick counter and the overflow flag are 0. `state` is IDLE.
- **IDLE:**
  - `launch` moves to BURN.
  - `v_valid` and `burnout` are ignored.
- **BURN:** on each `v_valid`:
  - acc += velocity*DT_US
  - cur_velocity = velocity
  - sample_count++
- **BURN, `burnout`:** moves to COAST and clears the tick counter.
  - If `v_valid` arrives in the same cycle, that sample is integrated first. The coast then starts from it.
- **COAST:**
  - The tick counter counts 0..DT_US-1. The step fires when the count reaches DT_US-1, and the counter then wraps to 0.
  - Each step: acc += cur_velocity*DT_US and sample_count++.
  - If cur_velocity > G_STEP: cur_velocity -= G_STEP.
  - Else: cur_velocity = 0, `apogee` pulses, and the block moves to DONE.
  - `v_valid` and `burnout` are ignored.
- **DONE:**
  - All outputs hold.
  - Only `resetb` leaves DONE.
  - `launch` is ignored.
- **Priority:** `launch` while not IDLE is ignored. `resetb` overrides every input in the same cycle.
- **Arithmetic:**
  - The products are 64×32 bits, zero-extended to ACC_W.
  - The accumulator saturates at all-ones and never wraps. Once saturated, it stays saturated until reset.
  - altitude_mm = acc / 10^12, truncated. It saturates to 64'hFFFF_FFFF_FFFF_FFFF if the quotient exceeds 64 bits.

## Timing
- cur_velocity, sample_count, state and the accumulator update on the clock edge that samples the event (`v_valid`, a coast step, `burnout`, `launch`). Their new values are visible the next cycle.
- altitude_mm is registered from the accumulator. It lags by one further cycle, so the total latency from `v_valid` to `altitude_mm` is 2 cycles.
- The first coast step fires DT_US cycles after the `burnout` edge. Later steps are spaced every DT_US cycles.
- `apogee` is high for exactly one cycle, in the same cycle that `state` first reads DONE. altitude_mm finalises one cycle after that.
- Reset mid-operation (BURN or COAST) zeroes everything on that edge. No pulse is emitted.

## Test plan
- **Reset:** hold `resetb`=1 for 2 cycles with random inputs -> all outputs 0, state=0, apogee never asserts.
- **Burn integration:**
  - Stimulus: `launch`, then 5 `v_valid` pulses with velocity=100_000_000_000 (100 m/s).
  - Each sample adds 2e12 fm (2 mm).
  - Required: sample_count=5, altitude_mm=10 two cycles after the last sample, state=1.
- **Coast to apogee:**
  - Stimulus: `launch`; one `v_valid` with velocity=1_000_000; `burnout`.
  - Coast velocities: 1_000_000 → 804_020 → 608_040 → 412_060 → 216_080 → 20_100 → 0.
  - Six coast steps (the 1_000_000 sample is integrated twice: once in BURN, once as the first coast step).
  - Required: apogee pulses on the 6th step, 120 cycles after `burnout`; state=3; cur_velocity=0; sample_count=7; altitude_mm=0.
- **Simultaneous `v_valid` and `burnout`:** same cycle, velocity=50_000_000_000.
  - That sample is integrated (1 mm).
  - cur_velocity=50_000_000_000 and state=2 next cycle.
  - The first coast step fires 20 cycles later.
- **Ignored inputs:**
  - `v_valid` in IDLE -> no change.
  - `launch` during BURN -> no change.
  - `launch` in DONE -> outputs hold.
- **Reset mid-coast:** assert `resetb` 50 cycles into COAST -> all zero next cycle, no apogee. A fresh `launch` then behaves as in the burn-integration test.
